// File: rtl/rk8e_dma_pkg.sv
// rk8e_dma_pkg: shared CPU major-state codes, DMA FSM encodings and the address incrementer.
// Honours build option RK8E_FIELD_CARRY_EN (address wrap carries into the field).
package rk8e_dma_pkg;

  localparam int MS_W = 5;

  // CPU major states seen on the sequencer state bus
  localparam logic [MS_W-1:0] MS_FETCH = 5'b00001;
  localparam logic [MS_W-1:0] MS_DEFER = 5'b00010;
  localparam logic [MS_W-1:0] MS_EXEC  = 5'b00100;
  localparam logic [MS_W-1:0] MS_DB0   = 5'b01000;
  localparam logic [MS_W-1:0] MS_DB1   = 5'b01001;
  localparam logic [MS_W-1:0] MS_DB2   = 5'b01010;

  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_FILL = 3'd1,
    DMA_REQ  = 3'd2,
    DMA_BRK  = 3'd3,
    DMA_CAPT = 3'd4,
    DMA_PUSH = 3'd5,
    DMA_ADV  = 3'd6,
    DMA_DONE = 3'd7
  } dma_state_t;

  function automatic logic [14:0] next_addr(input logic [14:0] addr);
    logic [11:0] low_s;
    logic [2:0]  fld_s;
    low_s = addr[11:0] + 12'd1;
`ifdef RK8E_FIELD_CARRY_EN
    fld_s = (low_s == 12'd0) ? (addr[14:12] + 3'd1) : addr[14:12];
`else
    fld_s = addr[14:12];
`endif
    return {fld_s, low_s};
  endfunction

endpackage

// File: rtl/rk8e_dma_if.sv
// rk8e_dma_if: data-break handshake with the CPU/memory-address stage plus the disk-buffer word streams.
interface rk8e_dma_if;
  import rk8e_dma_pkg::*;

  logic [MS_W-1:0] state;
  logic            brk_req;
  logic [14:0]     dmaAddr;
  logic [11:0]     disk2mem;
  logic            to_disk;
  logic [11:0]     mem2disk;
  logic [11:0]     din;
  logic            din_valid;
  logic            din_ready;
  logic [11:0]     dout;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    input  state, mem2disk, din, din_valid, dout_ready,
    output brk_req, dmaAddr, disk2mem, to_disk, din_ready, dout, dout_valid
  );

  modport slave (
    output state, mem2disk, din, din_valid, dout_ready,
    input  brk_req, dmaAddr, disk2mem, to_disk, din_ready, dout, dout_valid
  );

endinterface

// File: rtl/rk8e_dma.sv
// rk8e_dma: RK8E data-break engine moving one word per CPU break between disk buffer and memory.
// Build option RK8E_FIELD_CARRY_EN makes the 7777->0000 address wrap advance the field.
module rk8e_dma
  import rk8e_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        to_disk_cmd,
  input  logic [14:0] ca_in,
  input  logic [11:0] wc_in,
  rk8e_dma_if.master  bus,
  output logic        busy,
  output logic        done,
  output logic [14:0] ca_out,
  output logic [11:0] wc_out
);

  dma_state_t  state_r;
  dma_state_t  state_nx_s;
  logic [14:0] ca_r;
  logic [11:0] wc_r;
  logic        to_disk_r;
  logic [11:0] disk2mem_r;
  logic [11:0] dout_r;
  logic [14:0] ca_inc_s;
  logic [11:0] wc_inc_s;

  logic brk_req_s, din_ready_s, dout_valid_s, busy_s, done_s;
  logic brk_req_r, din_ready_r, dout_valid_r, busy_r, done_r;

  assign ca_inc_s = next_addr(ca_r);
  assign wc_inc_s = wc_r + 12'd1;

  // State register plus control outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= DMA_IDLE;
      brk_req_r    <= 1'b0;
      din_ready_r  <= 1'b0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      brk_req_r    <= brk_req_s;
      din_ready_r  <= din_ready_s;
      dout_valid_r <= dout_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      DMA_IDLE: begin
        if (start) state_nx_s = to_disk_cmd ? DMA_REQ : DMA_FILL;
        else       state_nx_s = DMA_IDLE;
      end
      DMA_FILL: begin
        if (bus.din_valid && din_ready_r) state_nx_s = DMA_REQ;
        else                              state_nx_s = DMA_FILL;
      end
      DMA_REQ: begin
        if (bus.state == MS_DB0) state_nx_s = DMA_BRK;
        else                     state_nx_s = DMA_REQ;
      end
      DMA_BRK: begin
        if (bus.state == MS_DB2) state_nx_s = to_disk_r ? DMA_CAPT : DMA_ADV;
        else                     state_nx_s = DMA_BRK;
      end
      DMA_CAPT: state_nx_s = DMA_PUSH;
      DMA_PUSH: begin
        if (bus.dout_ready) state_nx_s = DMA_ADV;
        else                state_nx_s = DMA_PUSH;
      end
      DMA_ADV: begin
        if (wc_inc_s == 12'd0) state_nx_s = DMA_DONE;
        else                   state_nx_s = to_disk_r ? DMA_REQ : DMA_FILL;
      end
      DMA_DONE: state_nx_s = DMA_IDLE;
      default:  state_nx_s = DMA_IDLE;
    endcase
  end

  // Control outputs for the state being entered, so the registered copies line up with it
  always_comb begin
    brk_req_s    = (state_nx_s == DMA_REQ);
    din_ready_s  = (state_nx_s == DMA_FILL);
    dout_valid_s = (state_nx_s == DMA_PUSH);
    busy_s       = (state_nx_s != DMA_IDLE);
    done_s       = (state_nx_s == DMA_DONE);
  end

  // Address, count, direction and data holding registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ca_r       <= 15'd0;
      wc_r       <= 12'd0;
      to_disk_r  <= 1'b0;
      disk2mem_r <= 12'd0;
      dout_r     <= 12'd0;
    end else begin
      case (state_r)
        DMA_IDLE: begin
          if (start) begin
            ca_r      <= ca_in;
            wc_r      <= wc_in;
            to_disk_r <= to_disk_cmd;
          end
        end
        DMA_FILL: begin
          if (bus.din_valid && din_ready_r) disk2mem_r <= bus.din;
        end
        DMA_CAPT: dout_r <= bus.mem2disk;
        DMA_ADV: begin
          ca_r <= ca_inc_s;
          wc_r <= wc_inc_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.brk_req    = brk_req_r;
  assign bus.din_ready  = din_ready_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.dmaAddr    = ca_r;
  assign bus.disk2mem   = disk2mem_r;
  assign bus.to_disk    = to_disk_r;
  assign bus.dout       = dout_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign ca_out         = ca_r;
  assign wc_out         = wc_r;

endmodule

// File: tb/tb_rk8e_dma.sv
// tb_rk8e_dma: randomized bench for rk8e_dma with a CPU break responder, memory array and disk stream models.
// Expected results come from word-count/address arithmetic; honours RK8E_FIELD_CARRY_EN.
module tb_rk8e_dma;
  import rk8e_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        to_disk_cmd;
  logic [14:0] ca_in;
  logic [11:0] wc_in;
  logic        busy, done;
  logic [14:0] ca_out;
  logic [11:0] wc_out;

  rk8e_dma_if bus();

  rk8e_dma dut (
    .clk(clk), .reset(reset), .start(start), .to_disk_cmd(to_disk_cmd),
    .ca_in(ca_in), .wc_in(wc_in), .bus(bus),
    .busy(busy), .done(done), .ca_out(ca_out), .wc_out(wc_out)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] mem [0:32767];
  logic [11:0] din_q[$];
  logic [14:0] wlog_addr[$];
  logic [11:0] wlog_data[$];
  logic [11:0] olog[$];
  bit          hold_sink = 1'b0;

  function automatic logic [14:0] ref_addr(input logic [14:0] base, input int i);
    int low, fld;
    low = int'(base[11:0]) + i;
    fld = int'(base[14:12]);
`ifdef RK8E_FIELD_CARRY_EN
    fld = (fld + low / 4096) % 8;
`endif
    low = low % 4096;
    return {3'(fld), 12'(low)};
  endfunction

  function automatic int ref_words(input logic [11:0] wc);
    return (wc == 12'd0) ? 4096 : 4096 - int'(wc);
  endfunction

  function automatic logic [4:0] other_state();
    logic [4:0] s;
    s = 5'($urandom);
    if (s == MS_DB0 || s == MS_DB2) s = MS_FETCH;
    return s;
  endfunction

  // CPU sequencer: answers a break request with DB0 then DB2, memory write at DB2, read data the cycle after
  initial begin : cpu
    int          phase;
    int          cnt;
    logic [14:0] cap_addr;
    phase = 0; cnt = 0; cap_addr = 15'd0;
    bus.state = MS_FETCH;
    bus.mem2disk = 12'd0;
    forever begin
      @(negedge clk);
      bus.mem2disk = 12'($urandom);
      bus.state = other_state();
      if (reset !== 1'b1) phase = 0;
      else begin
        if (phase == 0 && bus.brk_req === 1'b1) begin
          cnt = $urandom_range(0, 2);
          phase = 1;
        end
        if (phase == 1) begin
          if (bus.brk_req !== 1'b1) phase = 0;
          else if (cnt == 0) begin
            bus.state = MS_DB0;
            cnt = $urandom_range(0, 2);
            phase = 2;
          end else cnt--;
        end else if (phase == 2) begin
          if (cnt == 0) begin
            bus.state = MS_DB2;
            cap_addr = bus.dmaAddr;
            if (busy === 1'b1 && bus.to_disk === 1'b0) begin
              mem[cap_addr] = bus.disk2mem;
              wlog_addr.push_back(cap_addr);
              wlog_data.push_back(bus.disk2mem);
            end
            phase = 3;
          end else cnt--;
        end else if (phase == 3) begin
          bus.mem2disk = mem[cap_addr];
          phase = 0;
        end
      end
    end
  end

  // Disk buffer source with random valid gaps
  initial begin : src
    bit acc;
    acc = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 12'd0;
    forever begin
      @(negedge clk);
      if (acc && din_q.size() > 0) void'(din_q.pop_front());
      if (din_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.din_valid = 1'b1;
        bus.din = din_q[0];
      end else begin
        bus.din_valid = 1'b0;
        bus.din = 12'($urandom);
      end
      acc = (bus.din_valid && bus.din_ready === 1'b1 && reset === 1'b1);
    end
  end

  // Disk buffer sink with random ready stalls
  initial begin : snk
    bit          acc;
    logic [11:0] word;
    acc = 1'b0; word = 12'd0;
    bus.dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (acc) olog.push_back(word);
      bus.dout_ready = hold_sink ? 1'b0 : ($urandom_range(0, 2) != 0);
      acc = (bus.dout_valid === 1'b1 && bus.dout_ready && reset === 1'b1);
      word = bus.dout;
    end
  end

  task automatic do_xfer(input logic dir, input logic [14:0] ca, input logic [11:0] wc, input int limit,
                         output bit seen, output logic done_after, output logic busy_after);
    wlog_addr.delete(); wlog_data.delete(); olog.delete();
    @(negedge clk);
    start = 1'b1; to_disk_cmd = dir; ca_in = ca; wc_in = wc;
    @(negedge clk);
    start = 1'b0; to_disk_cmd = 1'($urandom); ca_in = 15'($urandom); wc_in = 12'($urandom);
    seen = 1'b0; done_after = 1'bx; busy_after = 1'bx;
    for (int c = 0; c < limit && !seen; c++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (seen) begin
      @(negedge clk);
      done_after = done; busy_after = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; to_disk_cmd = 1'b0; ca_in = 15'd0; wc_in = 12'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.brk_req, bus.din_ready, bus.dout_valid, busy, done, bus.to_disk,
         bus.dmaAddr, bus.disk2mem, bus.dout, wc_out, ca_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: brk/drdy/dval/busy/done/dir=%b%b%b%b%b%b addr=%o d2m=%o dout=%o wc=%o required all zero",
               bus.brk_req, bus.din_ready, bus.dout_valid, busy, done, bus.to_disk, bus.dmaAddr, bus.disk2mem, bus.dout, wc_out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_disk_to_mem();
    bit seen; logic da, ba;
    din_q = '{12'o1111, 12'o2222, 12'o3333};
    do_xfer(1'b0, 15'o10200, 12'o7775, 400, seen, da, ba);
    vectors++;
    if (!seen || da !== 1'b0 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL d2m_done: seen=%0d done_after=%b busy_after=%b required 1/0/0", seen, da, ba);
    end
    vectors++;
    if (wc_out !== 12'o0000 || ca_out !== 15'o10203) begin
      miscompares++;
      $display("FAIL d2m_regs: wc=%o ca=%o required 0000/10203", wc_out, ca_out);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= wlog_addr.size() || wlog_addr[i] !== 15'(15'o10200 + i) || wlog_data[i] !== 12'(12'o1111 * (i + 1))) begin
        miscompares++;
        $display("FAIL d2m_write%0d: %0d writes logged, addr/data=%o/%o required %o/%o", i, wlog_addr.size(),
                 (i < wlog_addr.size()) ? wlog_addr[i] : 15'h7fff, (i < wlog_data.size()) ? wlog_data[i] : 12'hfff,
                 15'(15'o10200 + i), 12'(12'o1111 * (i + 1)));
      end
    end
  endtask

  task automatic test_mem_to_disk();
    bit seen; logic da, ba;
    mem[15'o00100] = 12'o4321;
    mem[15'o00101] = 12'o1234;
    do_xfer(1'b1, 15'o00100, 12'o7776, 400, seen, da, ba);
    vectors++;
    if (!seen || olog.size() != 2 || olog[0] !== 12'o4321 || olog[1] !== 12'o1234) begin
      miscompares++;
      $display("FAIL m2d_stream: seen=%0d words=%0d first=%o second=%o required 1/2/4321/1234", seen, olog.size(),
               (olog.size() > 0) ? olog[0] : 12'hfff, (olog.size() > 1) ? olog[1] : 12'hfff);
    end
    vectors++;
    if (wc_out !== 12'o0000 || ca_out !== 15'o00102 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL m2d_regs: wc=%o ca=%o busy=%b required 0000/00102/0", wc_out, ca_out, busy);
    end
  endtask

  task automatic test_field_wrap();
    bit seen; logic da, ba;
    logic [14:0] exp1, exp2;
`ifdef RK8E_FIELD_CARRY_EN
    exp1 = 15'o30000; exp2 = 15'o00000;
`else
    exp1 = 15'o20000; exp2 = 15'o70000;
`endif
    din_q = '{12'($urandom), 12'($urandom)};
    do_xfer(1'b0, 15'o27777, 12'o7776, 400, seen, da, ba);
    vectors++;
    if (!seen || wlog_addr.size() != 2 || wlog_addr[0] !== 15'o27777 || wlog_addr[1] !== exp1) begin
      miscompares++;
      $display("FAIL wrap_field2: seen=%0d writes=%0d second addr=%o required %o", seen, wlog_addr.size(),
               (wlog_addr.size() > 1) ? wlog_addr[1] : 15'h7fff, exp1);
    end
    mem[15'o77777] = 12'($urandom);
    do_xfer(1'b1, 15'o77777, 12'o7777, 400, seen, da, ba);
    vectors++;
    if (!seen || ca_out !== exp2 || olog.size() != 1 || olog[0] !== mem[15'o77777]) begin
      miscompares++;
      $display("FAIL wrap_field7: seen=%0d ca=%o words=%0d required ca %o one word %o", seen, ca_out, olog.size(),
               exp2, mem[15'o77777]);
    end
  endtask

  task automatic test_push_hold();
    logic [11:0] w0, w1;
    bit ok;
    int c;
    w0 = 12'($urandom); w1 = 12'($urandom);
    mem[15'o00300] = w0; mem[15'o00301] = w1;
    olog.delete();
    hold_sink = 1'b1;
    @(negedge clk);
    start = 1'b1; to_disk_cmd = 1'b1; ca_in = 15'o00300; wc_in = 12'o7776;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (c = 0; c < 100 && !ok; c++) begin
      if (bus.dout_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_valid: dout_valid low after %0d cycles, required 1", c);
    end else begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        vectors++;
        if ({bus.dout_valid, bus.brk_req, bus.dout} !== {1'b1, 1'b0, w0}) begin
          miscompares++;
          $display("FAIL hold_cycle%0d: valid/brk/dout=%b/%b/%o required 1/0/%o", k, bus.dout_valid, bus.brk_req, bus.dout, w0);
        end
      end
    end
    hold_sink = 1'b0;
    ok = 1'b0;
    for (c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok || olog.size() != 2 || olog[0] !== w0 || olog[1] !== w1 || wc_out !== 12'd0) begin
      miscompares++;
      $display("FAIL hold_finish: done=%0d words=%0d wc=%o required done, %o then %o, wc 0000", ok, olog.size(), wc_out, w0, w1);
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    logic [14:0] ca, snap_ca;
    logic [11:0] snap_wc;
    bit ok;
    ca = 15'($urandom);
    din_q = '{12'($urandom), 12'($urandom), 12'($urandom)};
    wlog_addr.delete(); wlog_data.delete();
    @(negedge clk);
    start = 1'b1; to_disk_cmd = 1'b0; ca_in = ca; wc_in = 12'o7775;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (bus.brk_req === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    snap_ca = ca_out; snap_wc = wc_out;
    start = 1'b1; to_disk_cmd = 1'b1; ca_in = ~ca; wc_in = 12'o0001;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (!ok || ca_out !== snap_ca || wc_out !== snap_wc || snap_ca !== ca || snap_wc !== 12'o7775) begin
      miscompares++;
      $display("FAIL busy_start: req=%0d ca=%o wc=%o required %o/7775", ok, ca_out, wc_out, ca);
    end
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok || ca_out !== ref_addr(ca, 3) || wc_out !== 12'd0 || wlog_addr.size() != 3 || bus.to_disk !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_finish: done=%0d ca=%o writes=%0d dir=%b required ca %o, 3 writes, dir 0",
               ok, ca_out, wlog_addr.size(), bus.to_disk, ref_addr(ca, 3));
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int runs);
    for (int r = 0; r < runs; r++) begin
      logic        dir;
      logic [14:0] ca;
      logic [11:0] wc;
      logic [11:0] expw[$];
      int          n;
      bit          seen;
      logic        da, ba;
      dir = 1'($urandom);
      ca = 15'($urandom);
      if ($urandom_range(0, 2) == 0) ca[11:0] = 12'o7774 + 12'($urandom_range(0, 3));
      wc = 12'(4096 - $urandom_range(1, 6));
      n = ref_words(wc);
      expw.delete();
      for (int i = 0; i < n; i++) begin
        expw.push_back(12'($urandom));
        if (dir) mem[ref_addr(ca, i)] = expw[i];
      end
      if (!dir) din_q = expw;
      do_xfer(dir, ca, wc, 40 * n + 50, seen, da, ba);
      vectors++;
      if (!seen || da !== 1'b0 || ba !== 1'b0 || wc_out !== 12'd0 || ca_out !== ref_addr(ca, n)) begin
        miscompares++;
        $display("FAIL rand%0d_end: seen=%0d done_after=%b busy_after=%b wc=%o ca=%o required 1/0/0/0000/%o",
                 r, seen, da, ba, wc_out, ca_out, ref_addr(ca, n));
      end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (dir) begin
          if (i >= olog.size() || olog[i] !== expw[i]) begin
            miscompares++;
            $display("FAIL rand%0d_dout%0d: %0d words out, got %o required %o", r, i, olog.size(),
                     (i < olog.size()) ? olog[i] : 12'hfff, expw[i]);
          end
        end else begin
          if (i >= wlog_addr.size() || wlog_addr[i] !== ref_addr(ca, i) || wlog_data[i] !== expw[i]) begin
            miscompares++;
            $display("FAIL rand%0d_write%0d: %0d writes, got %o/%o required %o/%o", r, i, wlog_addr.size(),
                     (i < wlog_addr.size()) ? wlog_addr[i] : 15'h7fff, (i < wlog_data.size()) ? wlog_data[i] : 12'hfff,
                     ref_addr(ca, i), expw[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_in_brk();
    bit ok, prev, seen;
    int dones;
    logic da, ba;
    logic [14:0] ca;
    logic [11:0] w;
    din_q = '{12'($urandom), 12'($urandom)};
    @(negedge clk);
    start = 1'b1; to_disk_cmd = 1'b0; ca_in = 15'($urandom); wc_in = 12'o7776;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0; prev = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && bus.brk_req === 1'b0 && bus.din_ready === 1'b0 && prev) ok = 1'b1;
      else prev = (bus.brk_req === 1'b1);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (!ok || {bus.brk_req, bus.din_ready, bus.dout_valid, busy, done, bus.to_disk,
                bus.dmaAddr, bus.disk2mem, bus.dout, wc_out, ca_out} !== '0) begin
      miscompares++;
      $display("FAIL brk_reset: inbrk=%0d brk/drdy/dval/busy/done=%b%b%b%b%b addr=%o d2m=%o wc=%o required all zero",
               ok, bus.brk_req, bus.din_ready, bus.dout_valid, busy, done, bus.dmaAddr, bus.disk2mem, wc_out);
    end
    reset = 1'b1;
    din_q.delete();
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL brk_nodone: %0d cycles with done or busy after reset, required 0", dones);
    end
    ca = 15'($urandom); w = 12'($urandom);
    din_q = '{w};
    do_xfer(1'b0, ca, 12'o7777, 200, seen, da, ba);
    vectors++;
    if (!seen || wlog_addr.size() != 1 || wlog_addr[0] !== ca || wlog_data[0] !== w || ca_out !== ref_addr(ca, 1)) begin
      miscompares++;
      $display("FAIL brk_restart: seen=%0d writes=%0d ca=%o required one write %o=%o, ca %o",
               seen, wlog_addr.size(), ca_out, ca, w, ref_addr(ca, 1));
    end
  endtask

  task automatic test_wc_zero();
    logic [14:0] ca;
    logic [11:0] expw[$];
    bit seen;
    logic da, ba;
    int bad;
    ca = 15'($urandom);
    for (int i = 0; i < 4096; i++) begin
      expw.push_back(12'($urandom));
      mem[ref_addr(ca, i)] = expw[i];
    end
    do_xfer(1'b1, ca, 12'o0000, 4096 * 40, seen, da, ba);
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (i >= olog.size() || olog[i] !== expw[i]) bad++;
    end
    vectors++;
    if (!seen || olog.size() != 4096 || bad != 0 || ca_out !== ref_addr(ca, 4096) || wc_out !== 12'd0) begin
      miscompares++;
      $display("FAIL wc_zero: seen=%0d words=%0d wrong=%0d ca=%o required 4096 words, 0 wrong, ca %o",
               seen, olog.size(), bad, ca_out, ref_addr(ca, 4096));
    end
  endtask

  initial begin
    test_reset();
    test_disk_to_mem();
    test_mem_to_disk();
    test_field_wrap();
    test_push_hold();
    test_start_busy();
    test_random(16);
    test_reset_in_brk();
    test_wc_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
